// File: rtl/clock_pkg.sv
// Shared types, display constants and the 12-hour mapping helper for alarm_clock.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {SEC, MIN, HOUR} field_e;

  localparam logic [7:0] SEG_EN_TIME  = 8'b0011_1111;
  localparam logic [7:0] SEG_EN_ALARM = 8'b0011_1100;

  localparam logic [7:0] BCD_MAX_MIN_SEC = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;

  // Maps a packed-BCD 24-hour value to {pm, packed-BCD 12-hour value}.
  function automatic logic [8:0] h12_map(input logic [7:0] h_bcd);
    logic [4:0] h;
    logic [4:0] d;
    logic [7:0] d_bcd;
    logic       pm;
    h  = ({1'b0, h_bcd[7:4]} * 5'd10) + {1'b0, h_bcd[3:0]};
    pm = (h >= 5'd12);
    if (h == 5'd0) begin
      d = 5'd12;
    end else if (h > 5'd12) begin
      d = h - 5'd12;
    end else begin
      d = h;
    end
    if (d >= 5'd10) begin
      d_bcd = {4'd1, 4'(d - 5'd10)};
    end else begin
      d_bcd = {4'd0, d[3:0]};
    end
    return {pm, d_bcd};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD with carry chaining and stand-alone up/down stepping.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic carry_in,
  output bcd_t hi,
  output bcd_t lo,
  output logic carry_out
);

  localparam bcd_t MAX_HI = 4'((MOD - 1) / 10);
  localparam bcd_t MAX_LO = 4'((MOD - 1) % 10);

  logic at_max;
  logic at_zero;
  logic step_up;
  logic step_down;

  assign at_max    = (hi == MAX_HI) && (lo == MAX_LO);
  assign at_zero   = (hi == 4'd0) && (lo == 4'd0);
  // A carry always counts up; a lone button press steps, both buttons together cancel.
  assign step_up   = carry_in | (inc & ~dec);
  assign step_down = ~carry_in & dec & ~inc;
  assign carry_out = carry_in & at_max;

  // Digit register: wraps at MOD-1 going up and at 00 going down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 4'd0;
      lo <= 4'd0;
    end else if (step_up) begin
      if (at_max) begin
        hi <= 4'd0;
        lo <= 4'd0;
      end else if (lo == 4'd9) begin
        hi <= hi + 4'd1;
        lo <= 4'd0;
      end else begin
        lo <= lo + 4'd1;
      end
    end else if (step_down) begin
      if (at_zero) begin
        hi <= MAX_HI;
        lo <= MAX_LO;
      end else if (lo == 4'd0) begin
        hi <= hi - 4'd1;
        lo <= 4'd9;
      end else begin
        lo <= lo - 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_clock.sv
// Time-of-day clock with settable time, one daily alarm and 12/24-hour BCD display.
module alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 500,
  parameter bit H12           = 1'b0,
  parameter int RING_SECS     = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  sel,
  input  logic        alarm_edit,
  input  logic        alarm_en,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_clear,
  output logic [31:0] seg_content,
  output logic [7:0]  seg_dp,
  output logic [7:0]  seg_en,
  output logic        alarm_ring
);

  localparam int             DIV_W     = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]     RING_LAST = 8'(RING_SECS - 1);

  typedef enum logic {IDLE, RING} ring_state_e;

  logic [DIV_W-1:0] div_cnt;
  logic             sec_pulse;
  logic [2:0]       btn_q;
  logic [2:0]       btn_prev;
  logic             up_edge, down_edge, clear_edge;
  logic             set_mode;
  logic             alarm_sel;
  logic             tick_run;
  field_e           field;
  bcd_t             s_hi, s_lo, m_hi, m_lo, h_hi, h_lo, am_hi, am_lo, ah_hi, ah_lo;
  logic             s_carry, m_carry, h_carry, am_carry, ah_carry;
  logic             unused_carries;
  logic             match, match_q, trigger;
  ring_state_e      state, state_n;
  logic [7:0]       ring_cnt, ring_cnt_n;
  logic             colon;
  logic [7:0]       src_h;
  logic [8:0]       h12_val;
  logic [7:0]       disp_h;
  logic             pm;

  assign sec_pulse = (div_cnt == DIV_LAST);

  // Seconds divider: free-running, never stopped by set mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (sec_pulse) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Button sample register plus one cycle of history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q    <= 3'b000;
      btn_prev <= 3'b000;
    end else begin
      btn_q    <= {btn_clear, btn_down, btn_up};
      btn_prev <= btn_q;
    end
  end

  assign up_edge    = btn_q[0] & ~btn_prev[0];
  assign down_edge  = btn_q[1] & ~btn_prev[1];
  assign clear_edge = btn_q[2] & ~btn_prev[2];

  assign set_mode  = (sel != 3'b000) & ~alarm_edit;
  assign alarm_sel = (sel != 3'b000) & alarm_edit;
  assign tick_run  = sec_pulse & ~set_mode;

  // Field decode: the lowest set select bit wins.
  always_comb begin
    field = HOUR;
    if (sel[0]) begin
      field = SEC;
    end else if (sel[1]) begin
      field = MIN;
    end
  end

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk(clk), .rst_n(rst_n),
    .inc(set_mode & (field == SEC) & up_edge),
    .dec(set_mode & (field == SEC) & down_edge),
    .carry_in(tick_run), .hi(s_hi), .lo(s_lo), .carry_out(s_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk(clk), .rst_n(rst_n),
    .inc(set_mode & (field == MIN) & up_edge),
    .dec(set_mode & (field == MIN) & down_edge),
    .carry_in(s_carry), .hi(m_hi), .lo(m_lo), .carry_out(m_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hour (
    .clk(clk), .rst_n(rst_n),
    .inc(set_mode & (field == HOUR) & up_edge),
    .dec(set_mode & (field == HOUR) & down_edge),
    .carry_in(m_carry), .hi(h_hi), .lo(h_lo), .carry_out(h_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_alarm_min (
    .clk(clk), .rst_n(rst_n),
    .inc(alarm_sel & (field == MIN) & up_edge),
    .dec(alarm_sel & (field == MIN) & down_edge),
    .carry_in(1'b0), .hi(am_hi), .lo(am_lo), .carry_out(am_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_alarm_hour (
    .clk(clk), .rst_n(rst_n),
    .inc(alarm_sel & (field == HOUR) & up_edge),
    .dec(alarm_sel & (field == HOUR) & down_edge),
    .carry_in(1'b0), .hi(ah_hi), .lo(ah_lo), .carry_out(ah_carry)
  );

  assign unused_carries = h_carry | am_carry | ah_carry;

  assign match = alarm_en & ~set_mode
               & ({h_hi, h_lo} == {ah_hi, ah_lo})
               & ({m_hi, m_lo} == {am_hi, am_lo})
               & ({s_hi, s_lo} == 8'h00);
  assign trigger = match & ~match_q;

  // Alarm state register; match history makes each match fire once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ring_cnt <= 8'd0;
      match_q  <= 1'b0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
      match_q  <= match;
    end
  end

  // Alarm next state: cancel beats retrigger, which beats the seconds count.
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n    = RING;
          ring_cnt_n = 8'd0;
        end
      end
      RING: begin
        if (clear_edge || !alarm_en) begin
          state_n    = IDLE;
          ring_cnt_n = 8'd0;
        end else if (trigger) begin
          ring_cnt_n = 8'd0;
        end else if (sec_pulse) begin
          if (ring_cnt == RING_LAST) begin
            state_n    = IDLE;
            ring_cnt_n = 8'd0;
          end else begin
            ring_cnt_n = ring_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  assign alarm_ring = (state == RING);

  // Colon blink toggles once per running second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colon <= 1'b0;
    end else if (tick_run) begin
      colon <= ~colon;
    end
  end

  assign src_h   = alarm_edit ? {ah_hi, ah_lo} : {h_hi, h_lo};
  assign h12_val = h12_map(src_h);
  assign disp_h  = H12 ? h12_val[7:0] : src_h;
  assign pm      = H12 ? h12_val[8] : 1'b0;

  // Display mux between running time and the alarm setting.
  always_comb begin
    seg_content = {8'h00, disp_h, m_hi, m_lo, s_hi, s_lo};
    seg_en      = SEG_EN_TIME;
    if (alarm_edit) begin
      seg_content = {8'h00, disp_h, am_hi, am_lo, 8'h00};
      seg_en      = SEG_EN_ALARM;
    end
    seg_dp = {pm, 2'b00, colon, 1'b0, colon, 1'b0, colon};
    if (sel != 3'b000) begin
      seg_dp = {pm, 7'b0000000};
    end
  end

endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock: a 24-hour and a 12-hour instance share stimulus.
module tb_alarm_clock;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic        alarm_edit = 1'b0;
  logic        alarm_en = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_clear = 1'b0;

  logic [31:0] d24_content, d12_content;
  logic [7:0]  d24_dp, d12_dp, d24_en, d12_en;
  logic        d24_ring, d12_ring;

  int total = 0;
  int bad = 0;
  int cyc;

  alarm_clock #(.TICKS_PER_SEC(4), .H12(1'b0), .RING_SECS(3)) dut24 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .alarm_edit(alarm_edit), .alarm_en(alarm_en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
    .seg_content(d24_content), .seg_dp(d24_dp), .seg_en(d24_en), .alarm_ring(d24_ring)
  );

  alarm_clock #(.TICKS_PER_SEC(4), .H12(1'b1), .RING_SECS(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .alarm_edit(alarm_edit), .alarm_en(alarm_en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
    .seg_content(d12_content), .seg_dp(d12_dp), .seg_en(d12_en), .alarm_ring(d12_ring)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; edge 1 is the first edge after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  // One button pulse: high for one cycle, low for one; the field has moved on return.
  task automatic applyStimulus(input logic up, input logic down, input logic clr);
    btn_up = up;
    btn_down = down;
    btn_clear = clr;
    tick(1);
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_clear = 1'b0;
    tick(1);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    sel = 3'b000;
    alarm_edit = 1'b0;
    alarm_en = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_clear = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic waitCyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      tick(1);
      guard++;
    end
    if (cyc != n) checkOutput("wait_bound", 32'(cyc), 32'(n));
  endtask

  task automatic setAlarmOneMinute();
    alarm_edit = 1'b1;
    sel = 3'b010;
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");

    // Reset values while reset is held
    rst_n = 1'b0;
    tick(2);
    checkOutput("rst_content", d24_content, 32'h0000_0000);
    checkOutput("rst_dp", 32'(d24_dp), 32'h00);
    checkOutput("rst_en", 32'(d24_en), 32'h3F);
    checkOutput("rst_ring", 32'(d24_ring), 32'h0);
    checkOutput("rst_h12_content", d12_content, 32'h0012_0000);
    checkOutput("rst_h12_dp", 32'(d12_dp), 32'h00);

    // Hour setting, including 12-hour mapping at 12, 13, 01 and 23
    rst_n = 1'b1;
    sel = 3'b100;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("h12_content", d24_content, 32'h0012_0000);
    checkOutput("h12_dp24", 32'(d24_dp), 32'h00);
    checkOutput("h12_h12content", d12_content, 32'h0012_0000);
    checkOutput("h12_h12dp", 32'(d12_dp), 32'h80);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("h13_content", d24_content, 32'h0013_0000);
    checkOutput("h13_h12content", d12_content, 32'h0001_0000);
    checkOutput("h13_h12dp", 32'(d12_dp), 32'h80);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("h25up_content", d24_content, 32'h0001_0000);
    checkOutput("h25up_h12dp", 32'(d12_dp), 32'h00);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hdown_content", d24_content, 32'h0023_0000);
    checkOutput("hdown_h12content", d12_content, 32'h0011_0000);
    checkOutput("hdown_h12dp", 32'(d12_dp), 32'h80);

    // Minutes: simultaneous up/down is a no-op, then single steps with wrap
    sel = 3'b010;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("min_both", d24_content, 32'h0023_0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("min_up", d24_content, 32'h0023_0100);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("min_wrap_down", d24_content, 32'h0023_5900);
    sel = 3'b001;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sec_wrap_down", d24_content, 32'h0023_5959);

    // Back to run mode: exactly one second elapses in any 4 cycles -> midnight
    sel = 3'b000;
    tick(4);
    checkOutput("midnight", d24_content, 32'h0000_0000);
    checkOutput("midnight_h12", d12_content, 32'h0012_0000);

    // First carry into minutes at cycle 240, colon blink phase
    applyReset();
    waitCyc(239);
    checkOutput("c239_content", d24_content, 32'h0000_0059);
    checkOutput("c239_dp", 32'(d24_dp), 32'h15);
    waitCyc(240);
    checkOutput("c240_content", d24_content, 32'h0000_0100);
    checkOutput("c240_dp", 32'(d24_dp), 32'h00);

    // Alarm at 00:01 rings for 3 seconds
    applyReset();
    setAlarmOneMinute();
    checkOutput("aedit_content", d24_content, 32'h0000_0100);
    checkOutput("aedit_en", 32'(d24_en), 32'h3C);
    checkOutput("aedit_dp", 32'(d24_dp), 32'h00);
    checkOutput("aedit_h12content", d12_content, 32'h0012_0100);
    alarm_edit = 1'b0;
    sel = 3'b000;
    alarm_en = 1'b1;
    waitCyc(240);
    checkOutput("a240_ring", 32'(d24_ring), 32'h0);
    checkOutput("a240_content", d24_content, 32'h0000_0100);
    checkOutput("a240_en", 32'(d24_en), 32'h3F);
    waitCyc(241);
    checkOutput("a241_ring", 32'(d24_ring), 32'h1);
    waitCyc(251);
    checkOutput("a251_ring", 32'(d24_ring), 32'h1);
    waitCyc(252);
    checkOutput("a252_ring", 32'(d24_ring), 32'h0);

    // Clear while ringing, then asynchronous reset between edges
    applyReset();
    setAlarmOneMinute();
    alarm_edit = 1'b0;
    sel = 3'b000;
    alarm_en = 1'b1;
    waitCyc(241);
    checkOutput("c241_ring", 32'(d24_ring), 32'h1);
    waitCyc(245);
    btn_clear = 1'b1;
    tick(1);
    checkOutput("clr1_ring", 32'(d24_ring), 32'h1);
    tick(1);
    checkOutput("clr2_ring", 32'(d24_ring), 32'h0);
    btn_clear = 1'b0;
    tick(2);
    checkOutput("pre_arst_content", d24_content, 32'h0000_0102);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_content", d24_content, 32'h0000_0000);
    checkOutput("arst_dp", 32'(d24_dp), 32'h00);
    checkOutput("arst_en", 32'(d24_en), 32'h3F);
    checkOutput("arst_ring", 32'(d24_ring), 32'h0);
    checkOutput("arst_h12content", d12_content, 32'h0012_0000);
    checkOutput("arst_h12dp", 32'(d12_dp), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
